// File: rtl/fft_frame_packer.sv
// -----------------------------------------------------------------------------
// fft_frame_packer
//
// Producer end of the FFT result bus. Bins leave the butterfly datapath one
// complex sample per cycle in radix-2 bit-reversed order. This block puts them
// back into natural order in a 16-entry frame buffer. When the last bin of a
// frame arrives, it presents all 16 bins in parallel for the frequency
// analysis stage, together with a one-cycle fft_valid pulse. The buffer keeps
// accepting the next frame while the finished one is held on fft_d0..fft_d15.
//
// Parameters
//   DW      width of each signed component; a bus word is {re, im} = 2*DW bits
//   BITREV  1: the bin in arrival slot k is stored at bin bitrev4(k); 0: at k
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active-high
//   bin_valid      bin_re/bin_im carry a bin this cycle
//   bin_sof        with bin_valid: this bin is arrival slot 0
//   bin_re/bin_im  signed real / imaginary part of the incoming bin
//   err_clr        clears frame_err (a simultaneous set wins)
//   fft_valid      one-cycle pulse: a new frame is on fft_d0..fft_d15
//   fft_d0..15     bin n = {re, im}, held until the next completed frame
//   frame_cnt      frames emitted, modulo 64
//   frame_err      sticky: a frame was restarted by bin_sof before completion
// -----------------------------------------------------------------------------
module fft_frame_packer #(
    parameter int DW     = 16,
    parameter bit BITREV = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bin_valid,
    input  logic                 bin_sof,
    input  logic signed [DW-1:0] bin_re,
    input  logic signed [DW-1:0] bin_im,
    input  logic                 err_clr,
    output logic                 fft_valid,
    output logic [2*DW-1:0]      fft_d0,
    output logic [2*DW-1:0]      fft_d1,
    output logic [2*DW-1:0]      fft_d2,
    output logic [2*DW-1:0]      fft_d3,
    output logic [2*DW-1:0]      fft_d4,
    output logic [2*DW-1:0]      fft_d5,
    output logic [2*DW-1:0]      fft_d6,
    output logic [2*DW-1:0]      fft_d7,
    output logic [2*DW-1:0]      fft_d8,
    output logic [2*DW-1:0]      fft_d9,
    output logic [2*DW-1:0]      fft_d10,
    output logic [2*DW-1:0]      fft_d11,
    output logic [2*DW-1:0]      fft_d12,
    output logic [2*DW-1:0]      fft_d13,
    output logic [2*DW-1:0]      fft_d14,
    output logic [2*DW-1:0]      fft_d15,
    output logic [5:0]           frame_cnt,
    output logic                 frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for slot 0 (wr_idx == 0)
        ST_FILL = 2'd1    // slots 1..15 outstanding
    } fill_state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    fill_state_t     state;
    logic [3:0]      wr_idx;
    logic [2*DW-1:0] bin_buf [16];

    logic [3:0]      eff_p0;
    logic [3:0]      addr_p0;
    logic [2*DW-1:0] word_p0;
    logic            last_p0;
    logic            resync_p0;

    logic            vld_p1;
    logic [2*DW-1:0] frame_p1 [16];

    // ---- stage 0: slot resolution for the incoming bin ----
    // A qualified sof forces the slot back to 0 whatever the counter says,
    // so a restarted frame simply overwrites the stale partial slots.
    always_comb begin
        eff_p0    = (bin_valid && bin_sof) ? 4'd0 : wr_idx;
        addr_p0   = BITREV ? bitrev4(eff_p0) : eff_p0;
        word_p0   = {bin_re, bin_im};
        last_p0   = bin_valid && (eff_p0 == 4'd15);
        resync_p0 = bin_valid && bin_sof && (state == ST_FILL);
    end

    // ---- stage 1: buffer write, frame publish, control ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_idx    <= 4'd0;
            vld_p1    <= 1'b0;
            frame_cnt <= 6'd0;
            frame_err <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                bin_buf[i]  <= '0;
                frame_p1[i] <= '0;
            end
        end else begin
            vld_p1 <= 1'b0;

            if (bin_valid) begin
                bin_buf[addr_p0] <= word_p0;
                wr_idx           <= eff_p0 + 4'd1;
                state            <= (eff_p0 == 4'd15) ? ST_IDLE : ST_FILL;
            end

            // The final bin is still in flight to bin_buf, so it is bypassed
            // straight into its output slot. Later buffer writes never reach
            // frame_p1 until the next completion.
            if (last_p0) begin
                vld_p1    <= 1'b1;
                frame_cnt <= frame_cnt + 6'd1;
                for (int i = 0; i < 16; i++) begin
                    frame_p1[i] <= (4'(i) == addr_p0) ? word_p0 : bin_buf[i];
                end
            end

            if (resync_p0) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign fft_valid = vld_p1;
    assign fft_d0    = frame_p1[0];
    assign fft_d1    = frame_p1[1];
    assign fft_d2    = frame_p1[2];
    assign fft_d3    = frame_p1[3];
    assign fft_d4    = frame_p1[4];
    assign fft_d5    = frame_p1[5];
    assign fft_d6    = frame_p1[6];
    assign fft_d7    = frame_p1[7];
    assign fft_d8    = frame_p1[8];
    assign fft_d9    = frame_p1[9];
    assign fft_d10   = frame_p1[10];
    assign fft_d11   = frame_p1[11];
    assign fft_d12   = frame_p1[12];
    assign fft_d13   = frame_p1[13];
    assign fft_d14   = frame_p1[14];
    assign fft_d15   = frame_p1[15];

endmodule

// File: tb/tb_fft_frame_packer.sv
module tb_fft_frame_packer;

    typedef logic [15:0][31:0] frame_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               bin_valid = 1'b0;
    logic               bin_sof = 1'b0;
    logic signed [15:0] bin_re = '0;
    logic signed [15:0] bin_im = '0;
    logic               err_clr = 1'b0;

    logic        fft_valid, fft_valid0;
    logic [5:0]  frame_cnt, frame_cnt0;
    logic        frame_err, frame_err0;
    logic [31:0] q1 [16];
    logic [31:0] q0 [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fft_frame_packer #(.DW(16), .BITREV(1'b1)) dut (
        .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_sof(bin_sof),
        .bin_re(bin_re), .bin_im(bin_im), .err_clr(err_clr),
        .fft_valid(fft_valid),
        .fft_d0(q1[0]),   .fft_d1(q1[1]),   .fft_d2(q1[2]),   .fft_d3(q1[3]),
        .fft_d4(q1[4]),   .fft_d5(q1[5]),   .fft_d6(q1[6]),   .fft_d7(q1[7]),
        .fft_d8(q1[8]),   .fft_d9(q1[9]),   .fft_d10(q1[10]), .fft_d11(q1[11]),
        .fft_d12(q1[12]), .fft_d13(q1[13]), .fft_d14(q1[14]), .fft_d15(q1[15]),
        .frame_cnt(frame_cnt), .frame_err(frame_err)
    );

    fft_frame_packer #(.DW(16), .BITREV(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_sof(bin_sof),
        .bin_re(bin_re), .bin_im(bin_im), .err_clr(err_clr),
        .fft_valid(fft_valid0),
        .fft_d0(q0[0]),   .fft_d1(q0[1]),   .fft_d2(q0[2]),   .fft_d3(q0[3]),
        .fft_d4(q0[4]),   .fft_d5(q0[5]),   .fft_d6(q0[6]),   .fft_d7(q0[7]),
        .fft_d8(q0[8]),   .fft_d9(q0[9]),   .fft_d10(q0[10]), .fft_d11(q0[11]),
        .fft_d12(q0[12]), .fft_d13(q0[13]), .fft_d14(q0[14]), .fft_d15(q0[15]),
        .frame_cnt(frame_cnt0), .frame_err(frame_err0)
    );

    // Reference: natural-order bin n is the bin that arrived in slot rev(n).
    function automatic logic [3:0] rev4(input logic [3:0] k);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = k[3-i];
        return r;
    endfunction

    function automatic frame_t expect_frame(input frame_t f, input bit rev);
        frame_t e;
        for (int n = 0; n < 16; n++) e[n] = rev ? f[rev4(4'(n))] : f[n];
        return e;
    endfunction

    function automatic frame_t ramp_frame();
        frame_t f;
        for (int k = 0; k < 16; k++) f[k] = {16'(k), 16'(-k)};
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int k = 0; k < 16; k++) f[k] = $urandom;
        return f;
    endfunction

    task automatic step(input logic v, input logic s, input logic [31:0] w, input logic clr);
        @(negedge clk);
        bin_valid = v;
        bin_sof   = s;
        bin_re    = w[31:16];
        bin_im    = w[15:0];
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    // Sends a 16-bin frame (sof on slot 0), optionally idling gap_len cycles
    // after slots gap_a and gap_b. Reports pulses seen and fft_valid after slot 15.
    task automatic send_frame(input frame_t f, input int gap_a, input int gap_b,
                              input int gap_len, output int pulses,
                              output logic last_v, output logic last_v0);
        pulses  = 0;
        last_v  = 1'b0;
        last_v0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k == 0, f[k], 1'b0);
            if (fft_valid) pulses++;
            if (k == 15) begin
                last_v  = fft_valid;
                last_v0 = fft_valid0;
            end
            if (k == gap_a || k == gap_b) begin
                for (int g = 0; g < gap_len; g++) begin
                    step(1'b0, 1'b0, 32'h0, 1'b0);
                    if (fft_valid) pulses++;
                end
            end
        end
        bin_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (fft_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", fft_valid); end
        total++; if (frame_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", frame_cnt); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", frame_err); end
        for (int n = 0; n < 16; n++) begin
            total++;
            if (q1[n] !== 32'h0) begin bad++; $display("FAIL reset_d%0d got=%h want=0", n, q1[n]); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        frame_t f, e;
        int p; logic lv, lv0;
        f = ramp_frame();
        e = expect_frame(f, 1'b1);
        send_frame(f, -1, -1, 0, p, lv, lv0);
        total++; if (lv !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", lv); end
        total++; if (p != 1) begin bad++; $display("FAIL basic_pulses got=%0d want=1", p); end
        total++; if (q1[8] !== 32'h0001FFFF) begin bad++; $display("FAIL basic_d8 got=%h want=0001ffff", q1[8]); end
        total++; if (q1[1] !== 32'h0008FFF8) begin bad++; $display("FAIL basic_d1 got=%h want=0008fff8", q1[1]); end
        total++; if (q1[15] !== 32'h000FFFF1) begin bad++; $display("FAIL basic_d15 got=%h want=000ffff1", q1[15]); end
        total++; if (frame_cnt !== 6'd1) begin bad++; $display("FAIL basic_cnt got=%0d want=1", frame_cnt); end
        for (int n = 0; n < 16; n++) begin
            total++;
            if (q1[n] !== e[n]) begin bad++; $display("FAIL basic_d%0d got=%h want=%h", n, q1[n], e[n]); end
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (fft_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got=%b want=0", fft_valid); end
        for (int n = 0; n < 16; n++) begin
            total++;
            if (q1[n] !== e[n]) begin bad++; $display("FAIL basic_hold_d%0d got=%h want=%h", n, q1[n], e[n]); end
        end
    endtask

    task automatic test_gaps();
        frame_t f, e;
        int p; logic lv, lv0;
        f = ramp_frame();
        e = expect_frame(f, 1'b1);
        send_frame(f, 4, 11, 3, p, lv, lv0);
        total++; if (lv !== 1'b1) begin bad++; $display("FAIL gaps_valid got=%b want=1", lv); end
        total++; if (p != 1) begin bad++; $display("FAIL gaps_pulses got=%0d want=1", p); end
        total++; if (frame_cnt !== 6'd2) begin bad++; $display("FAIL gaps_cnt got=%0d want=2", frame_cnt); end
        for (int n = 0; n < 16; n++) begin
            total++;
            if (q1[n] !== e[n]) begin bad++; $display("FAIL gaps_d%0d got=%h want=%h", n, q1[n], e[n]); end
        end
        f = rand_frame();
        e = expect_frame(f, 1'b1);
        send_frame(f, int'($urandom_range(0, 14)), int'($urandom_range(0, 14)),
                   int'($urandom_range(1, 5)), p, lv, lv0);
        total++; if (p != 1 || lv !== 1'b1) begin bad++; $display("FAIL gaps_rand_pulse got=%0d/%b want=1/1", p, lv); end
        for (int n = 0; n < 16; n++) begin
            total++;
            if (q1[n] !== e[n]) begin bad++; $display("FAIL gaps_rand_d%0d got=%h want=%h", n, q1[n], e[n]); end
        end
    endtask

    task automatic test_back_to_back();
        frame_t fa, fb, ea, eb;
        int pq[$];
        logic [5:0] c0;
        logic held;
        fa = rand_frame();
        fb = rand_frame();
        ea = expect_frame(fa, 1'b1);
        eb = expect_frame(fb, 1'b1);
        c0 = frame_cnt;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, (i % 16) == 0, (i < 16) ? fa[i] : fb[i-16], 1'b0);
            if (fft_valid) pq.push_back(i);
            if (i == 15) begin
                total++; if (frame_cnt !== 6'(c0 + 1)) begin bad++; $display("FAIL b2b_cnt1 got=%0d want=%0d", frame_cnt, 6'(c0 + 1)); end
                for (int n = 0; n < 16; n++) begin
                    total++;
                    if (q1[n] !== ea[n]) begin bad++; $display("FAIL b2b_a_d%0d got=%h want=%h", n, q1[n], ea[n]); end
                end
            end else if (i > 15 && i < 31) begin
                held = 1'b1;
                for (int n = 0; n < 16; n++) if (q1[n] !== ea[n]) held = 1'b0;
                total++; if (!held) begin bad++; $display("FAIL b2b_hold cycle=%0d got=changed want=frame_a", i); end
            end else if (i == 31) begin
                total++; if (frame_cnt !== 6'(c0 + 2)) begin bad++; $display("FAIL b2b_cnt2 got=%0d want=%0d", frame_cnt, 6'(c0 + 2)); end
                for (int n = 0; n < 16; n++) begin
                    total++;
                    if (q1[n] !== eb[n]) begin bad++; $display("FAIL b2b_b_d%0d got=%h want=%h", n, q1[n], eb[n]); end
                end
            end
        end
        bin_valid = 1'b0;
        total++;
        if (pq.size() != 2 || pq[0] != 15 || pq[1] != 31) begin
            bad++;
            $display("FAIL b2b_spacing got=%0d pulses want=2 at cycles 15,31", pq.size());
        end
    endtask

    task automatic test_resync();
        frame_t fa, fb, eb;
        int p, pp; logic lv, lv0;
        fa = rand_frame();
        fb = rand_frame();
        eb = expect_frame(fb, 1'b1);
        pp = 0;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, k == 0, fa[k], 1'b0);
            if (fft_valid) pp++;
        end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL resync_err_pre got=%b want=0", frame_err); end
        send_frame(fb, -1, -1, 0, p, lv, lv0);
        total++; if (p + pp != 1 || lv !== 1'b1) begin bad++; $display("FAIL resync_pulses got=%0d want=1", p + pp); end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL resync_err got=%b want=1", frame_err); end
        for (int n = 0; n < 16; n++) begin
            total++;
            if (q1[n] !== eb[n]) begin bad++; $display("FAIL resync_d%0d got=%h want=%h", n, q1[n], eb[n]); end
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL resync_clr got=%b want=0", frame_err); end
        // set and clear in the same cycle: set wins
        for (int k = 0; k < 3; k++) step(1'b1, k == 0, fa[k], 1'b0);
        step(1'b1, 1'b1, fb[0], 1'b1);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL resync_set_wins got=%b want=1", frame_err); end
        for (int k = 1; k < 16; k++) step(1'b1, 1'b0, fb[k], 1'b0);
        total++; if (fft_valid !== 1'b1) begin bad++; $display("FAIL resync2_valid got=%b want=1", fft_valid); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL resync_clr2 got=%b want=0", frame_err); end
        // sof with the counter at 0 is a normal start
        send_frame(fa, -1, -1, 0, p, lv, lv0);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL resync_clean_err got=%b want=0", frame_err); end
    endtask

    task automatic test_async_reset();
        frame_t fa, fb, eb;
        int p; logic lv, lv0;
        fa = rand_frame();
        fb = rand_frame();
        eb = expect_frame(fb, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b1, k == 0, fa[k], 1'b0);
        @(negedge clk);
        #2;
        rst       = 1'b1;
        bin_valid = 1'b0;
        bin_sof   = 1'b0;
        #1;
        total++; if (fft_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", fft_valid); end
        total++; if (frame_cnt !== 6'd0) begin bad++; $display("FAIL arst_cnt got=%0d want=0", frame_cnt); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL arst_err got=%b want=0", frame_err); end
        for (int n = 0; n < 16; n++) begin
            total++;
            if (q1[n] !== 32'h0) begin bad++; $display("FAIL arst_d%0d got=%h want=0", n, q1[n]); end
        end
        @(negedge clk);
        rst = 1'b0;
        send_frame(fb, -1, -1, 0, p, lv, lv0);
        total++; if (p != 1 || lv !== 1'b1) begin bad++; $display("FAIL arst_frame_pulse got=%0d/%b want=1/1", p, lv); end
        total++; if (frame_cnt !== 6'd1) begin bad++; $display("FAIL arst_frame_cnt got=%0d want=1", frame_cnt); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL arst_frame_err got=%b want=0", frame_err); end
        for (int n = 0; n < 16; n++) begin
            total++;
            if (q1[n] !== eb[n]) begin bad++; $display("FAIL arst_frame_d%0d got=%h want=%h", n, q1[n], eb[n]); end
        end
    endtask

    task automatic test_cnt_wrap();
        frame_t f, e;
        int p; logic lv, lv0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 64; j++) begin
            f = rand_frame();
            send_frame(f, -1, -1, 0, p, lv, lv0);
            total++;
            if (frame_cnt !== 6'(j % 64) || lv !== 1'b1) begin
                bad++;
                $display("FAIL wrap_cnt frame=%0d got=%0d/%b want=%0d/1", j, frame_cnt, lv, j % 64);
            end
        end
        e = expect_frame(f, 1'b1);
        for (int n = 0; n < 16; n++) begin
            total++;
            if (q1[n] !== e[n]) begin bad++; $display("FAIL wrap_d%0d got=%h want=%h", n, q1[n], e[n]); end
        end
    endtask

    task automatic test_bitrev0();
        frame_t f;
        int p; logic lv, lv0;
        f = ramp_frame();
        send_frame(f, -1, -1, 0, p, lv, lv0);
        total++; if (lv0 !== 1'b1) begin bad++; $display("FAIL nobr_valid got=%b want=1", lv0); end
        total++; if (frame_cnt0 !== 6'd1) begin bad++; $display("FAIL nobr_cnt got=%0d want=1", frame_cnt0); end
        total++; if (frame_err0 !== 1'b0) begin bad++; $display("FAIL nobr_err got=%b want=0", frame_err0); end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (q0[k] !== {16'(k), 16'(-k)}) begin
                bad++;
                $display("FAIL nobr_d%0d got=%h want=%h", k, q0[k], {16'(k), 16'(-k)});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_resync();
        test_async_reset();
        test_cnt_wrap();
        test_bitrev0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
